// File: rtl/trajectory_history.sv
// rtl/trajectory_history.sv - ring buffer of recent ball positions rendered as a fading dot trail
//
// Ports:
//   clk_in, rst_n_in        pixel clock, asynchronous active-low reset
//   hcount_in, vcount_in    current raster position
//   data_valid_in           current pixel is in the active area
//   new_frame_in            one-cycle pulse at the start of each frame
//   pos_x_in, pos_y_in      detected ball position, captured at frame start
//   pos_valid_in            detected position is meaningful
//   clear_in                synchronous flush of the history
//   trajectory_pixel_out    trail colour (RGB888) or 0, two cycles after the raster inputs
//   data_valid_out          data_valid_in aligned with trajectory_pixel_out
//   count_out               number of valid stored positions

module trajectory_history #(
    parameter int          DEPTH      = 8,
    parameter int          RADIUS     = 3,
    parameter logic [23:0] BASE_COLOR = 24'hFF0000
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic [10:0]                hcount_in,
    input  logic [9:0]                 vcount_in,
    input  logic                       data_valid_in,
    input  logic                       new_frame_in,
    input  logic [10:0]                pos_x_in,
    input  logic [9:0]                 pos_y_in,
    input  logic                       pos_valid_in,
    input  logic                       clear_in,
    output logic [23:0]                trajectory_pixel_out,
    output logic                       data_valid_out,
    output logic [$clog2(DEPTH+1)-1:0] count_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    localparam logic signed [11:0] RAD_P = 12'(RADIUS);
    localparam logic signed [11:0] RAD_N = -RAD_P;

    logic [10:0]      entry_x [DEPTH];
    logic [9:0]       entry_y [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic capture;
    assign capture = new_frame_in && pos_valid_in && !clear_in;

    // Buffer contents need no reset: liveness is governed by count.
    always_ff @(posedge clk_in) begin
        if (capture) begin
            entry_x[wr_ptr] <= pos_x_in;
            entry_y[wr_ptr] <= pos_y_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear_in) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (capture) begin
            // DEPTH is a power of two, so the pointer wraps on its own.
            wr_ptr <= wr_ptr + PTR_W'(1);
            if (count != CNT_W'(DEPTH))
                count <= count + CNT_W'(1);
        end
    end

    assign count_out = count;

    // Stage 1: per-slot hit test and age.
    logic [PTR_W-1:0] age_c [DEPTH];
    logic [DEPTH-1:0] hit_c;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            logic signed [11:0] dx;
            logic signed [11:0] dy;
            logic               live;
            age_c[i] = wr_ptr - PTR_W'(1) - PTR_W'(i);
            live     = CNT_W'(age_c[i]) < count;
            // Zero-extended 12-bit differences keep edge dots clipped instead of wrapping.
            dx       = signed'({1'b0, hcount_in}) - signed'({1'b0, entry_x[i]});
            dy       = signed'({2'b0, vcount_in}) - signed'({2'b0, entry_y[i]});
            hit_c[i] = live && (dx >= RAD_N) && (dx <= RAD_P)
                            && (dy >= RAD_N) && (dy <= RAD_P);
        end
    end

    logic             s1_valid;
    logic [DEPTH-1:0] s1_hit;
    logic [PTR_W-1:0] s1_age [DEPTH];

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1_valid <= 1'b0;
            s1_hit   <= '0;
            for (int i = 0; i < DEPTH; i++)
                s1_age[i] <= '0;
        end else begin
            s1_valid <= data_valid_in;
            s1_hit   <= hit_c;
            for (int i = 0; i < DEPTH; i++)
                s1_age[i] <= age_c[i];
        end
    end

    // Stage 2: youngest hit wins, colour fades by one bit every two ages.
    logic             any_hit;
    logic [PTR_W-1:0] best_age;
    logic [PTR_W-1:0] shamt;
    logic [23:0]      color;

    always_comb begin
        any_hit  = 1'b0;
        best_age = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (s1_hit[i] && (!any_hit || s1_age[i] < best_age)) begin
                any_hit  = 1'b1;
                best_age = s1_age[i];
            end
        end
        shamt = best_age >> 1;
        color = {BASE_COLOR[23:16] >> shamt,
                 BASE_COLOR[15:8]  >> shamt,
                 BASE_COLOR[7:0]   >> shamt};
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            trajectory_pixel_out <= '0;
            data_valid_out       <= 1'b0;
        end else begin
            trajectory_pixel_out <= (any_hit && s1_valid) ? color : 24'h000000;
            data_valid_out       <= s1_valid;
        end
    end

endmodule

// File: tb/tb_trajectory_history.sv
// tb/tb_trajectory_history.sv - directed self-checking bench for trajectory_history

module tb_trajectory_history;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        data_valid_in;
    logic        new_frame_in;
    logic [10:0] pos_x_in;
    logic [9:0]  pos_y_in;
    logic        pos_valid_in;
    logic        clear_in;
    logic [23:0] trajectory_pixel_out;
    logic        data_valid_out;
    logic [3:0]  count_out;

    int n_tests = 0;
    int n_fail  = 0;

    trajectory_history #(.DEPTH(8), .RADIUS(3), .BASE_COLOR(24'hFF0000)) dut (
        .clk_in               (clk_in),
        .rst_n_in             (rst_n_in),
        .hcount_in            (hcount_in),
        .vcount_in            (vcount_in),
        .data_valid_in        (data_valid_in),
        .new_frame_in         (new_frame_in),
        .pos_x_in             (pos_x_in),
        .pos_y_in             (pos_y_in),
        .pos_valid_in         (pos_valid_in),
        .clear_in             (clear_in),
        .trajectory_pixel_out (trajectory_pixel_out),
        .data_valid_out       (data_valid_out),
        .count_out            (count_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic capture(input int x, input int y, input logic valid);
        pos_x_in     = 11'(x);
        pos_y_in     = 10'(y);
        pos_valid_in = valid;
        new_frame_in = 1'b1;
        tick();
        new_frame_in = 1'b0;
        pos_valid_in = 1'b0;
    endtask

    task automatic clear_hist();
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
    endtask

    task automatic probe(input string tag, input int x, input int y, input logic [23:0] exp);
        hcount_in     = 11'(x);
        vcount_in     = 10'(y);
        data_valid_in = 1'b1;
        tick();
        tick();
        check(tag, {8'h0, trajectory_pixel_out}, {8'h0, exp});
        data_valid_in = 1'b0;
    endtask

    initial begin
        rst_n_in      = 1'b0;
        hcount_in     = '0;
        vcount_in     = '0;
        data_valid_in = 1'b0;
        new_frame_in  = 1'b0;
        pos_x_in      = '0;
        pos_y_in      = '0;
        pos_valid_in  = 1'b0;
        clear_in      = 1'b0;
        tick();
        tick();
        check("reset_pixel", {8'h0, trajectory_pixel_out}, 32'h0);
        check("reset_dv", {31'h0, data_valid_out}, 32'h0);
        check("reset_count", {28'h0, count_out}, 32'h0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        tick();

        // Single dot at (100,50), streamed scan of row 50.
        capture(100, 50, 1'b1);
        check("count_one", {28'h0, count_out}, 32'd1);
        vcount_in     = 10'd50;
        data_valid_in = 1'b1;
        for (int h = 94; h <= 106; h++) begin
            hcount_in = 11'(h);
            tick();
            // Output now reflects the pixel applied one cycle before this one (2-cycle latency).
            if (h >= 95) begin
                logic [23:0] exp;
                exp = ((h - 1) >= 97 && (h - 1) <= 103) ? 24'hFF0000 : 24'h000000;
                check($sformatf("scan_h%0d", h - 1), {8'h0, trajectory_pixel_out}, {8'h0, exp});
            end
        end
        data_valid_in = 1'b0;

        // Four dots along row 10, fade every two ages.
        clear_hist();
        capture(10, 10, 1'b1);
        capture(20, 10, 1'b1);
        capture(30, 10, 1'b1);
        capture(40, 10, 1'b1);
        check("count_four", {28'h0, count_out}, 32'd4);
        probe("age0_x40", 40, 10, 24'hFF0000);
        probe("age1_x30", 30, 10, 24'hFF0000);
        probe("age2_x20", 20, 10, 24'h7F0000);
        probe("age3_x10", 10, 10, 24'h7F0000);

        // Ten captures overflow the 8-entry ring.
        clear_hist();
        for (int k = 0; k < 10; k++)
            capture(k * 10, 10, 1'b1);
        check("count_sat", {28'h0, count_out}, 32'd8);
        probe("overwritten_x0", 0, 10, 24'h000000);
        probe("overwritten_x10", 10, 10, 24'h000000);
        probe("age7_x20", 20, 10, 24'h1F0000);
        probe("age0_x90", 90, 10, 24'hFF0000);

        // Overlap and screen-edge handling.
        clear_hist();
        capture(50, 50, 1'b1);
        capture(52, 50, 1'b1);
        probe("overlap_51", 51, 50, 24'hFF0000);
        capture(0, 0, 1'b1);
        probe("corner_00", 0, 0, 24'hFF0000);
        probe("no_wrap_2047", 2047, 0, 24'h000000);
        probe("clip_x3", 3, 3, 24'hFF0000);

        // Invalid capture is ignored; clear beats simultaneous capture.
        capture(200, 200, 1'b0);
        check("invalid_keep", {28'h0, count_out}, 32'd3);
        probe("invalid_no_dot", 200, 200, 24'h000000);
        clear_in = 1'b1;
        capture(300, 100, 1'b1);
        clear_in = 1'b0;
        check("clear_count", {28'h0, count_out}, 32'd0);
        probe("clear_no_old", 0, 0, 24'h000000);
        probe("clear_no_new", 300, 100, 24'h000000);

        // Valid flag gating and asynchronous reset.
        capture(100, 50, 1'b1);
        hcount_in     = 11'd100;
        vcount_in     = 10'd50;
        data_valid_in = 1'b0;
        tick();
        tick();
        check("dv0_pixel", {8'h0, trajectory_pixel_out}, 32'h0);
        check("dv0_dvout", {31'h0, data_valid_out}, 32'h0);
        data_valid_in = 1'b1;
        tick();
        tick();
        check("dv1_pixel", {8'h0, trajectory_pixel_out}, 32'h00FF0000);
        check("dv1_dvout", {31'h0, data_valid_out}, 32'h1);
        #2;
        rst_n_in = 1'b0;
        #1;
        check("async_rst_pixel", {8'h0, trajectory_pixel_out}, 32'h0);
        check("async_rst_dv", {31'h0, data_valid_out}, 32'h0);
        check("async_rst_count", {28'h0, count_out}, 32'h0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        tick();
        tick();
        check("post_rst_empty", {8'h0, trajectory_pixel_out}, 32'h0);
        check("post_rst_dv", {31'h0, data_valid_out}, 32'h1);
        data_valid_in = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
